banked_lane_ram: RTL

//  Banked, lane-sliced single-port synchronous RAM with valid/ready request and response channels.

---
 rtl/banked_lane_ram.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/banked_lane_ram.sv
// Banked, lane-sliced single-port RAM with valid/ready request and response channels.
// Latency: writes are posted; a read gives rsp_valid READ_LATENCY cycles after its accept cycle.
// Backpressure: req_ready is low outside IDLE; the response is held until rsp_valid & rsp_ready.
module banked_lane_ram #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_BANKS    = 4,
  parameter int NUM_LANES    = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_LANES-1:0]  req_lane_en,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy
);

  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int ROW_W  = ADDR_WIDTH - BANK_W;
  localparam int DEPTH  = 1 << ROW_W;
  localparam int LANE_W = DATA_WIDTH / NUM_LANES;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_RESP    = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  w_capture;

  logic                  w_req_fire;
  logic                  w_wr_accept;
  logic                  w_rd_accept;
  logic [BANK_W-1:0]     w_req_bank;
  logic [ROW_W-1:0]      w_req_row;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic [BANK_W-1:0]     w_rd_bank;
  logic [ROW_W-1:0]      w_rd_row;
  logic [DATA_WIDTH-1:0] w_rd_word;

  // Reset gates req_ready so a write presented alongside rst is never performed.
  assign req_ready   = (r_state == S_IDLE) && !rst;
  assign w_req_fire  = req_valid && req_ready;
  assign w_wr_accept = w_req_fire && req_we;
  assign w_rd_accept = w_req_fire && !req_we;

  assign w_req_bank  = req_addr[ADDR_WIDTH-1 -: BANK_W];
  assign w_req_row   = req_addr[ROW_W-1:0];

  // With a one-cycle latency the data is captured on the accept edge itself,
  // before the address register holds it, so read straight from the request.
  assign w_rd_addr   = (r_state == S_IDLE) ? req_addr : r_addr;
  assign w_rd_bank   = w_rd_addr[ADDR_WIDTH-1 -: BANK_W];
  assign w_rd_row    = w_rd_addr[ROW_W-1:0];

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [LANE_W-1:0] r_mem [NUM_BANKS][DEPTH];

    // Posted lane write; storage is deliberately left unreset.
    always_ff @(posedge clk) begin
      if (w_wr_accept && req_lane_en[l]) begin
        r_mem[w_req_bank][w_req_row] <= req_wdata[l*LANE_W +: LANE_W];
      end
    end

    assign w_rd_word[l*LANE_W +: LANE_W] = r_mem[w_rd_bank][w_rd_row];
  end

  // Next-state logic: count out the read latency, then hold the response until taken.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rd_accept) begin
          w_cnt_nxt = CNT_W'(READ_LATENCY - 1);
          if (READ_LATENCY == 1) begin
            w_state_nxt = S_RESP;
            w_capture   = 1'b1;
          end else begin
            w_state_nxt = S_RD_WAIT;
          end
        end
      end
      S_RD_WAIT: begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
        // The move to RESP happens on the edge where the count reaches zero.
        if (r_cnt <= CNT_W'(1)) begin
          w_state_nxt = S_RESP;
          w_capture   = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, latency counter, latched read address and response data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_rd_accept) begin
        r_addr <= req_addr;
      end
      if (w_capture) begin
        r_rdata <= w_rd_word;
      end
    end
  end

  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = r_rdata;
  assign busy      = (r_state != S_IDLE);

endmodule
